// File: rtl/div.sv
// Sequential signed divider: 32-iteration restoring shift-subtract on operand
// magnitudes, sign-corrected quotient to lo and remainder to hi.
module div #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH-1:0] hi,
  output logic signed [WIDTH-1:0] lo,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   rq;
  logic [2*WIDTH-1:0]   rq_step;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic                 rem_ge;
  logic                 sa, sb;
  logic [CNT_W-1:0]     cnt;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // One restoring step: the remainder shifted left keeps its carry bit so the
  // compare against |B| is a full WIDTH+1-bit unsigned compare.
  assign rem_sh   = rq[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, dvs};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign rq_step  = rem_ge ? {rem_diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1}
                           : {rq[2*WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (B == '0) ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(WIDTH-1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq       <= '0;
      dvs      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa       <= A[WIDTH-1];
            sb       <= B[WIDTH-1];
            rq       <= {{WIDTH{1'b0}}, neg_if(A, A[WIDTH-1])};
            dvs      <= neg_if(B, B[WIDTH-1]);
            cnt      <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        CALC: begin
          rq  <= rq_step;
          cnt <= cnt + CNT_W'(1);
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dvs == '0) begin
            // Negating |A| by the latched sign recovers the original dividend.
            hi       <= neg_if(rq[WIDTH-1:0], sa);
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            lo <= neg_if(rq[WIDTH-1:0], sa ^ sb);
            hi <= neg_if(rq[2*WIDTH-1:WIDTH], sa);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for the sequential signed divider: vector table plus
// hand-written busy, back-to-back and mid-operation reset sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int tests = 0;
  int fails = 0;

  div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands with start high and let the next rising edge accept them.
  task automatic accept(input logic [31:0] av, input logic [31:0] bv, input string name);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({name, " busy_after_accept"}, {31'b0, busy}, 32'd1);
    chk({name, " dz_cleared"}, {31'b0, div_zero}, 32'd0);
    chk({name, " done_low_after_accept"}, {31'b0, done}, 32'd0);
  endtask

  // Count edges until done; check latency, busy span and results.
  task automatic wait_done(input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                           input logic edz, input string name);
    int n = 0;
    int busy_n = 0;
    bit seen = 0;
    while (n < lat + 5 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
      else if (busy) busy_n++;
    end
    if (!seen) begin
      chk({name, " done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " latency"}, n, lat);
      chk({name, " busy_cycles"}, busy_n, lat - 1);
      chk({name, " busy_low_at_done"}, {31'b0, busy}, 32'd0);
      chk({name, " lo"}, lo, elo);
      chk({name, " hi"}, hi, ehi);
      chk({name, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
    end
  endtask

  task automatic do_op(input vec_t v, input string name);
    accept(v.a, v.b, name);
    wait_done(v.dz ? 1 : 33, v.lo, v.hi, v.dz, name);
    @(posedge clk);
    #1;
    chk({name, " done_pulse_ends"}, {31'b0, done}, 32'd0);
    chk({name, " lo_holds"}, lo, v.lo);
    chk({name, " hi_holds"}, hi, v.hi);
  endtask

  initial begin
    int done_seen;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
    vecs[6]  = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[7]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[8]  = '{32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
    vecs[10] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};

    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset div_zero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Start during busy must be ignored; operands are not re-sampled.
    accept(32'd100, 32'd7, "busy_ign");
    repeat (5) begin @(posedge clk); #1; end
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(27, 32'd14, 32'd2, 1'b0, "busy_ign");

    // Divide by zero then a valid op: flag clears at the next acceptance.
    @(posedge clk);
    #1;
    accept(32'd5, 32'd0, "dz_then");
    wait_done(1, 32'hFFFF_FFFF, 32'd5, 1'b1, "dz_then");
    @(posedge clk);
    #1;
    accept(32'd100, 32'd7, "dz_clear");
    wait_done(33, 32'd14, 32'd2, 1'b0, "dz_clear");

    // Back-to-back: start raised in the done cycle is accepted at the next edge.
    accept(32'hFFFF_FF9C, 32'd7, "b2b");
    wait_done(33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "b2b_second");

    // Mid-operation asynchronous reset.
    @(posedge clk);
    #1;
    accept(32'd100, 32'd7, "rst_mid");
    repeat (9) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid hi", hi, 32'd0);
    chk("rst_mid lo", lo, 32'd0);
    chk("rst_mid busy", {31'b0, busy}, 32'd0);
    chk("rst_mid done", {31'b0, done}, 32'd0);
    chk("rst_mid div_zero", {31'b0, div_zero}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("rst_mid no_done", done_seen, 32'd0);
    do_op(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
